elevator_call_latch: RTL and testbench
======================================

// Module: elevator_call_latch
// PURPOSE
//  Upstream request stage for the elevator controller. Synchronises and debounces the six raw
//  active-low buttons (FB1..3 in-car, CALL1..3 hall), latches each press as a pending per-floor
//  request, clears a request when the controller services that floor, and runs a SCAN direction
//  FSM that presents the next target floor and travel direction to the controller.
// PARAMETERS
//  DB_CYCLES   16   consecutive identical samples needed to accept a new button level
//  NFLOORS     3    number of floors (fixed at 3; floors encoded 1..3)
// PORTS
//  clk      in   1  single system clock, rising edge
//  reset    in   1  asynchronous, active-low reset
//  FB       in   3  in-car floor buttons [3:1], raw, active-low, asynchronous
//  CALL     in   3  hall call buttons [3:1], raw, active-low, asynchronous
//  floor    in   2  current floor from controller, 1..3 (0 = invalid)
//  svc      in   1  one-cycle pulse: controller opened the door at `floor`
//  req      out  3  pending requests [3:1], 1 = pending
//  target   out  2  next floor to serve, 1..3
//  UD       out  1  travel direction, 1 = up, 0 = down
//  busy     out  1  |req
// BEHAVIOUR
//  Reset (async assert, sync release): req=0, target=1, UD=1, busy=0, FSM=IDLE,
//   sync FFs=1 (released), debounce counters=0, accepted levels=1.
//  Sync: each of the 6 inputs passes through a 2-FF synchroniser.
//  Debounce: per input, counter increments while synced sample != accepted level, clears when
//   equal; at count==DB_CYCLES-1 the accepted level flips and the counter clears.
//   Press = accepted level 1->0 (one-cycle internal strobe). Release produces no event.
//  Latency: raw falling edge held stable -> req[n] set after 2+DB_CYCLES+1 clk edges.
//  Request latch: req[n] <= (req[n] | pressFB[n] | pressCALL[n]) & ~(svc && floor==n).
//   Same-cycle press and service at the same floor: clear wins (car is already there).
//   svc with floor==0: ignored, no clear. Press on an already pending floor: no change.
//  Direction FSM (states IDLE, UP, DOWN), evaluated every cycle on registered req, floor:
//   above = req bits > floor, below = req bits < floor.
//   IDLE: above -> UP; else below -> DOWN; else stay.
//   UP:   above -> stay, target = lowest pending floor above; else below -> DOWN; else IDLE.
//   DOWN: below -> stay, target = highest pending floor below; else above -> UP; else IDLE.
//   On entering UP/DOWN, target is the nearest floor in the new direction.
//   In IDLE, target = floor.
//   UD = 0 only in DOWN; 1 in IDLE and UP.
//   floor==0: FSM and target hold.
//   No transition may skip a pending floor in the current direction.
//  Reset mid-operation: all pending requests discarded; buttons held through reset are not
//   latched until released and pressed again (accepted level starts released).
// CONFIGURATION
//  `DEBOUNCE_EN defined: debounce counters as above.
//  Not defined: the synchronised level is the accepted level directly (no counter);
//   latency = 3 clk edges; DB_CYCLES unused.
// STRUCTURE
//  Package elevator_pkg: floor constants FLR1..FLR3 (2'd1..2'd3), direction constants UP/DN,
//   FSM state typedef (IDLE, UP, DOWN), DB_CYCLES default.
//  Sub-module button_debounce (2-FF sync + optional counter, press strobe out), instantiated
//   6 times. Request latch and FSM live in the top module.
// TESTING
//  1 Reset low, then high, no buttons -> req=000, target=1, UD=1, busy=0.
//  2 floor=1, FB[3] low 3 cycles then high -> req unchanged.
//    FB[3] held low DB_CYCLES+5 cycles -> req=100 at cycle 2+DB_CYCLES+1, UD=1, target=3.
//  3 floor=2, req=101, FSM UP -> target=3; svc with floor=3 -> req=001, FSM DOWN, UD=0, target=1.
//  4 floor=2: CALL[2] press strobe in the same cycle as svc -> req[2] stays 0.
//  5 req=010, svc pulse with floor=0 -> req stays 010, target/UD hold.
//  6 req=111 mid-run, reset asserted asynchronously -> outputs at reset values before next clk.
//    FB[1] held through reset release -> req stays 000.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call-latch slice.
//
// Contents:
//   FLR1..FLR3         floor encodings (0 means "no valid floor")
//   DIR_UP / DIR_DN    encodings of the UD travel-direction output
//   dir_state_t        direction FSM states IDLE, UP, DOWN
//   DB_CYCLES_DEFAULT  default debounce length, used only when DEBOUNCE_EN is defined
package elevator_pkg;

  localparam logic [1:0] FLR1 = 2'd1;
  localparam logic [1:0] FLR2 = 2'd2;
  localparam logic [1:0] FLR3 = 2'd3;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int DB_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_state_t;

endpackage

// File: rtl/button_debounce.sv
// One raw active-low push button turned into a clean one-cycle press strobe.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   raw    in   raw button level, active-low, asynchronous to clk
//   press  out  one-cycle strobe when the accepted level goes released -> pressed
//
// Configuration macro DEBOUNCE_EN:
//   defined     a new level is accepted only after DB_CYCLES identical samples
//   undefined   the synchronised level is taken as the accepted level directly
//
// A button that is already held when reset is released is not reported. The
// press has to be released and pressed again first.
module button_debounce
  import elevator_pkg::*;
`ifdef DEBOUNCE_EN
  #(parameter int DB_CYCLES = DB_CYCLES_DEFAULT)
`endif
  (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  logic       sync1;
  logic       sync2;
  logic       level;
  logic       level_d;
  logic [1:0] settle;
  logic       armed;

  // Two-flop synchroniser. It resets to the released level (1).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] count;

  // Count the consecutive samples that differ from the accepted level.
  // After DB_CYCLES of them the accepted level flips. Any agreeing
  // sample restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      level <= 1'b1;
    end else if (sync2 == level) begin
      count <= '0;
    end else if (count == CW'(DB_CYCLES - 1)) begin
      level <= sync2;
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
`else
  assign level = sync2;
`endif

  // settle marks the point where the synchroniser holds real samples
  // rather than its reset value. The button arms only after it has been
  // seen released. level_d delays the accepted level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle  <= 2'b00;
      armed   <= 1'b0;
      level_d <= 1'b1;
    end else begin
      settle  <= {settle[0], 1'b1};
      level_d <= level;
      if (settle[1] && sync2)
        armed <= 1'b1;
    end
  end

  assign press = armed & level_d & ~level;

endmodule

// File: rtl/elevator_call_latch.sv
// Request stage in front of the elevator controller. It cleans the six
// buttons, latches pending per-floor requests and runs a SCAN direction FSM
// that gives the controller its next target floor and travel direction.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low reset
//   FB      in   [3:1] in-car floor buttons, raw, active-low
//   CALL    in   [3:1] hall call buttons, raw, active-low
//   floor   in   current floor 1..3 from the controller (0 = invalid)
//   svc     in   one-cycle pulse: door opened at `floor`
//   req     out  [3:1] pending requests
//   target  out  next floor to serve
//   UD      out  travel direction, 1 = up, 0 = down
//   busy    out  any request pending
//
// Configuration macro DEBOUNCE_EN enables the per-button debounce counters.
module elevator_call_latch
  import elevator_pkg::*;
  #(parameter int NFLOORS = 3
`ifdef DEBOUNCE_EN
  , parameter int DB_CYCLES = DB_CYCLES_DEFAULT
`endif
  ) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS:1]   FB,
  input  logic [NFLOORS:1]   CALL,
  input  logic [1:0]         floor,
  input  logic               svc,
  output logic [NFLOORS:1]   req,
  output logic [1:0]         target,
  output logic               UD,
  output logic               busy
);

  logic [NFLOORS:1] press_fb;
  logic [NFLOORS:1] press_call;
  logic [NFLOORS:1] clr;
  logic [NFLOORS:1] above_m;
  logic [NFLOORS:1] below_m;
  logic [1:0]       low_above;
  logic [1:0]       high_below;
  logic             any_above;
  logic             any_below;
  dir_state_t       state;

  for (genvar i = 1; i <= NFLOORS; i++) begin : g_btn
`ifdef DEBOUNCE_EN
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_fb (
      .clk(clk), .reset(reset), .raw(FB[i]), .press(press_fb[i]));
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_call (
      .clk(clk), .reset(reset), .raw(CALL[i]), .press(press_call[i]));
`else
    button_debounce u_fb (
      .clk(clk), .reset(reset), .raw(FB[i]), .press(press_fb[i]));
    button_debounce u_call (
      .clk(clk), .reset(reset), .raw(CALL[i]), .press(press_call[i]));
`endif
  end

  // Service clears only the floor the door opened at. floor == 0 never matches.
  always_comb begin
    clr = '0;
    for (int i = 1; i <= NFLOORS; i++)
      clr[i] = svc && (int'(floor) == i);
  end

  // When a press and a service arrive together for the same floor, the
  // clear wins because the car is already at that floor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      req <= '0;
    else
      req <= (req | press_fb | press_call) & ~clr;
  end

  assign busy = |req;

  // Split the pending requests into those above and those below the car.
  always_comb begin
    above_m = '0;
    below_m = '0;
    for (int i = 1; i <= NFLOORS; i++) begin
      if (i > int'(floor)) above_m[i] = req[i];
      if (i < int'(floor)) below_m[i] = req[i];
    end
  end

  assign any_above  = |above_m;
  assign any_below  = |below_m;
  // Going up, aim for the nearest pending floor above. Going down, aim for
  // the nearest pending floor below. This way the car never passes a
  // pending floor.
  assign low_above  = above_m[1] ? FLR1 : (above_m[2] ? FLR2 : FLR3);
  assign high_below = below_m[3] ? FLR3 : (below_m[2] ? FLR2 : FLR1);

  // SCAN direction FSM. target and UD are registered. An invalid floor
  // holds everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      target <= FLR1;
      UD     <= DIR_UP;
    end else if (floor != 2'd0) begin
      case (state)
        UP: begin
          if (any_above) begin
            target <= low_above;
          end else if (any_below) begin
            state  <= DOWN;
            target <= high_below;
            UD     <= DIR_DN;
          end else begin
            state  <= IDLE;
            target <= floor;
            UD     <= DIR_UP;
          end
        end
        DOWN: begin
          if (any_below) begin
            target <= high_below;
          end else if (any_above) begin
            state  <= UP;
            target <= low_above;
            UD     <= DIR_UP;
          end else begin
            state  <= IDLE;
            target <= floor;
            UD     <= DIR_UP;
          end
        end
        default: begin
          if (any_above) begin
            state  <= UP;
            target <= low_above;
            UD     <= DIR_UP;
          end else if (any_below) begin
            state  <= DOWN;
            target <= high_below;
            UD     <= DIR_DN;
          end else begin
            target <= floor;
            UD     <= DIR_UP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_call_latch.sv
// Self-checking bench for elevator_call_latch. It uses a table of directed
// steps, hand-written corner sequences and a randomized run against a
// behavioural model. It works with or without DEBOUNCE_EN defined.
module tb_elevator_call_latch;

`ifdef DEBOUNCE_EN
  localparam int LAT = 2 + elevator_pkg::DB_CYCLES_DEFAULT + 1;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = LAT + 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:1] fb = 3'b111;
  logic [3:1] call = 3'b111;
  logic [1:0] floor = 2'd1;
  logic       svc = 1'b0;
  logic [3:1] req;
  logic [1:0] target;
  logic       ud;
  logic       busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:1] fb;
    logic [3:1] call;
    logic [1:0] flr;
    logic       svc;
    logic [3:1] exp_req;
    logic [1:0] exp_tgt;
    logic       exp_ud;
  } vec_t;

  vec_t vecs [16];

  // Reference model state: pending set, travel mode (0 idle, 1 up, 2 down), outputs.
  logic [3:1] m_req;
  int         m_mode;
  logic [1:0] m_tgt;
  logic       m_ud;

  elevator_call_latch dut (
    .clk(clk), .reset(reset), .FB(fb), .CALL(call), .floor(floor), .svc(svc),
    .req(req), .target(target), .UD(ud), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [3:1] exp_req,
                              input logic [1:0] exp_tgt, input logic exp_ud);
    checks++;
    if (req !== exp_req || target !== exp_tgt || ud !== exp_ud || busy !== (|exp_req)) begin
      failures++;
      $display("[TB] FAIL %s: got req=%b target=%0d UD=%b busy=%b, want req=%b target=%0d UD=%b busy=%b",
               name, req, target, ud, busy, exp_req, exp_tgt, exp_ud, |exp_req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fb    = 3'b111;
    call  = 3'b111;
    svc   = 1'b0;
    floor = 2'd1;
    tick(3);
    reset = 1'b1;
    tick(5);
  endtask

  // Drive one table step. Set the floor, optionally press and release the
  // buttons, optionally pulse svc, then let the FSM settle.
  task automatic apply_stimulus(input vec_t v);
    floor = v.flr;
    tick(2);
    if (v.fb != 3'b000 || v.call != 3'b000) begin
      fb   = ~v.fb;
      call = ~v.call;
      tick(LAT + 2);
      fb   = 3'b111;
      call = 3'b111;
      tick(LAT + 3);
    end
    if (v.svc) begin
      svc = 1'b1;
      tick(1);
      svc = 1'b0;
    end
    tick(3);
  endtask

  // One clock edge of the specified behaviour. The FSM sees the pending set
  // from before the edge. The pending set then adds presses and drops the
  // serviced floor.
  task automatic model_step(input logic [3:1] pv, input logic [1:0] flr, input logic sv);
    int lo;
    int hi;
    lo = 0;
    hi = 0;
    for (int f = 3; f >= 1; f--) if (m_req[f] && f > int'(flr)) lo = f;
    for (int f = 1; f <= 3; f++) if (m_req[f] && f < int'(flr)) hi = f;
    if (flr != 2'd0) begin
      if (m_mode == 1) begin
        if (lo != 0) m_tgt = 2'(lo);
        else if (hi != 0) begin m_mode = 2; m_tgt = 2'(hi); end
        else begin m_mode = 0; m_tgt = flr; end
      end else if (m_mode == 2) begin
        if (hi != 0) m_tgt = 2'(hi);
        else if (lo != 0) begin m_mode = 1; m_tgt = 2'(lo); end
        else begin m_mode = 0; m_tgt = flr; end
      end else begin
        if (lo != 0) begin m_mode = 1; m_tgt = 2'(lo); end
        else if (hi != 0) begin m_mode = 2; m_tgt = 2'(hi); end
        else m_tgt = flr;
      end
      m_ud = (m_mode != 2);
    end
    for (int f = 1; f <= 3; f++)
      m_req[f] = (m_req[f] | pv[f]) & ~(sv && int'(flr) == f);
  endtask

  initial begin
    int         press_at [6];
    int         last_chg [6];
    logic [5:0] raw;
    logic [3:1] pv;
    int         cyc;

    vecs[0]  = '{3'b100, 3'b000, 2'd1, 1'b0, 3'b100, 2'd3, 1'b1};
    vecs[1]  = '{3'b000, 3'b001, 2'd2, 1'b0, 3'b101, 2'd3, 1'b1};
    vecs[2]  = '{3'b000, 3'b000, 2'd3, 1'b1, 3'b001, 2'd1, 1'b0};
    vecs[3]  = '{3'b000, 3'b010, 2'd2, 1'b0, 3'b011, 2'd1, 1'b0};
    vecs[4]  = '{3'b000, 3'b000, 2'd2, 1'b1, 3'b001, 2'd1, 1'b0};
    vecs[5]  = '{3'b000, 3'b000, 2'd1, 1'b1, 3'b000, 2'd1, 1'b1};
    vecs[6]  = '{3'b100, 3'b010, 2'd1, 1'b0, 3'b110, 2'd2, 1'b1};
    vecs[7]  = '{3'b000, 3'b000, 2'd2, 1'b1, 3'b100, 2'd3, 1'b1};
    vecs[8]  = '{3'b001, 3'b000, 2'd3, 1'b0, 3'b101, 2'd1, 1'b0};
    vecs[9]  = '{3'b000, 3'b000, 2'd3, 1'b1, 3'b001, 2'd1, 1'b0};
    vecs[10] = '{3'b000, 3'b000, 2'd0, 1'b1, 3'b001, 2'd1, 1'b0};
    vecs[11] = '{3'b000, 3'b000, 2'd1, 1'b1, 3'b000, 2'd1, 1'b1};
    vecs[12] = '{3'b000, 3'b000, 2'd2, 1'b0, 3'b000, 2'd2, 1'b1};
    vecs[13] = '{3'b011, 3'b000, 2'd3, 1'b0, 3'b011, 2'd2, 1'b0};
    vecs[14] = '{3'b000, 3'b000, 2'd2, 1'b1, 3'b001, 2'd1, 1'b0};
    vecs[15] = '{3'b000, 3'b000, 2'd1, 1'b1, 3'b000, 2'd1, 1'b1};

    // Outputs during and after reset.
    tick(2);
    check_output("in_reset", 3'b000, 2'd1, 1'b1);
    do_reset();
    check_output("after_reset", 3'b000, 2'd1, 1'b1);

`ifdef DEBOUNCE_EN
    // A short glitch must not be accepted.
    fb = 3'b011;
    tick(3);
    fb = 3'b111;
    tick(LAT + 3);
    check_output("glitch_ignored", 3'b000, 2'd1, 1'b1);
`endif

    // Press latency measured from the raw falling edge.
    fb = 3'b011;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == LAT - 1) check_output("latency_before", 3'b000, 2'd1, 1'b1);
      if (k == LAT)     check_output("latency_set", 3'b100, 2'd1, 1'b1);
    end
    @(negedge clk);
    check_output("latency_fsm_up", 3'b100, 2'd3, 1'b1);
    fb = 3'b111;
    tick(LAT + 3);

    // Table-driven sequence.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_tgt, vecs[i].exp_ud);
    end

    // A press strobe in the same cycle as service at that floor is cleared.
    do_reset();
    floor = 2'd2;
    tick(3);
    call = 3'b101;
    tick(LAT - 1);
    svc = 1'b1;
    tick(1);
    svc = 1'b0;
    check_output("press_svc_same_cycle", 3'b000, 2'd2, 1'b1);
    tick(3);
    check_output("press_svc_later", 3'b000, 2'd2, 1'b1);
    call = 3'b111;
    tick(LAT + 3);

    // Async reset mid-run, with FB[1] held through the reset release.
    fb = 3'b000;
    tick(LAT + 2);
    check_output("all_pending", 3'b111, 2'd3, 1'b1);
    fb = 3'b110;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_output("async_reset", 3'b000, 2'd1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    tick(LAT + 6);
    check_output("held_through_reset", 3'b000, 2'd2, 1'b1);
    fb = 3'b111;
    tick(LAT + 3);
    fb = 3'b110;
    tick(LAT + 2);
    check_output("repress_after_reset", 3'b001, 2'd1, 1'b0);
    fb = 3'b111;
    tick(LAT + 3);

    // Randomized run against the behavioural model.
    do_reset();
    m_req  = 3'b000;
    m_mode = 0;
    m_tgt  = 2'd1;
    m_ud   = 1'b1;
    raw    = 6'h3f;
    cyc    = 0;
    for (int b = 0; b < 6; b++) begin
      press_at[b] = -1;
      last_chg[b] = 0;
    end
    for (int c = 0; c < 4000; c++) begin
      check_output($sformatf("random@%0d", cyc), m_req, m_tgt, m_ud);
      if ($urandom_range(0, 2) == 0) floor = 2'($urandom_range(0, 3));
      svc = ($urandom_range(0, 5) == 0);
      for (int b = 0; b < 6; b++) begin
        if (cyc - last_chg[b] >= HOLD && $urandom_range(0, 15) == 0) begin
          raw[b] = ~raw[b];
          last_chg[b] = cyc;
          if (!raw[b]) press_at[b] = cyc + LAT;
        end
      end
      fb   = raw[2:0];
      call = raw[5:3];
      pv = 3'b000;
      for (int b = 0; b < 6; b++)
        if (press_at[b] == cyc + 1) pv[(b % 3) + 1] = 1'b1;
      model_step(pv, floor, svc);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
